// File: rtl/packet_checker.sv
// Stream sink that checks pattern-generator packets (packet number replicated in all lanes)
// and accumulates pass/fail statistics, with optional periodic TREADY throttling.
module packet_checker #(
    parameter int THROTTLE_PERIOD = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         arm,
    input  logic [63:0]  expected_count,
    input  logic [7:0]   expected_length,
    input  logic [511:0] AXIS_RX_TDATA,
    input  logic [63:0]  AXIS_RX_TKEEP,
    input  logic         AXIS_RX_TVALID,
    input  logic         AXIS_RX_TLAST,
    output logic         AXIS_RX_TREADY,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [63:0]  packets_rcvd,
    output logic [31:0]  error_count,
    output logic [63:0]  first_err_pkt,
    output logic [2:0]   first_err_code
);

    localparam int CW = (THROTTLE_PERIOD > 0) ? $clog2(THROTTLE_PERIOD + 1) : 1;
    localparam logic [CW-1:0] THROTTLE_MAX = CW'(THROTTLE_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] throttle_q, throttle_d;
    logic [63:0]   expCount_q, expCount_d;
    logic [7:0]    expLength_q, expLength_d;
    logic [63:0]   expPkt_q, expPkt_d;
    logic [7:0]    beatIdx_q, beatIdx_d;
    logic [2:0]    sticky_q, sticky_d;
    logic [63:0]   packetsRcvd_q, packetsRcvd_d;
    logic [31:0]   errorCount_q, errorCount_d;
    logic [63:0]   firstErrPkt_q, firstErrPkt_d;
    logic [2:0]    firstErrCode_q, firstErrCode_d;

    logic       treadyInt;
    logic       beatFire;
    logic       dataErr;
    logic [2:0] beatCode;
    logic [2:0] pktCode;

    always_comb begin
        treadyInt = 1'b0;
        if (state_q != IDLE) begin
            treadyInt = (THROTTLE_PERIOD == 0) ? 1'b1 : (throttle_q != THROTTLE_MAX);
        end
    end

    assign AXIS_RX_TREADY = treadyInt;
    assign beatFire       = AXIS_RX_TVALID & treadyInt;
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = (state_q == DONE) && (errorCount_q == 32'd0);
    assign packets_rcvd   = packetsRcvd_q;
    assign error_count    = errorCount_q;
    assign first_err_pkt  = firstErrPkt_q;
    assign first_err_code = firstErrCode_q;

    // Classify the current beat; the lowest-numbered error code takes priority, both within
    // a beat and across the beats of one packet.
    always_comb begin
        dataErr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (AXIS_RX_TDATA[i*64 +: 64] != expPkt_q) begin
                dataErr = 1'b1;
            end
        end
        beatCode = 3'd0;
        if (dataErr) begin
            beatCode = 3'd1;
        end else if (AXIS_RX_TKEEP != {64{1'b1}}) begin
            beatCode = 3'd2;
        end else if (AXIS_RX_TLAST && (beatIdx_q < expLength_q)) begin
            beatCode = 3'd3;
        end else if (!AXIS_RX_TLAST && (beatIdx_q == expLength_q)) begin
            beatCode = 3'd4;
        end else if (state_q == DONE) begin
            beatCode = 3'd5;
        end
        pktCode = sticky_q;
        if ((beatCode != 3'd0) && ((sticky_q == 3'd0) || (beatCode < sticky_q))) begin
            pktCode = beatCode;
        end
    end

    always_comb begin
        state_d        = state_q;
        throttle_d     = (throttle_q == THROTTLE_MAX) ? '0 : throttle_q + 1'b1;
        expCount_d     = expCount_q;
        expLength_d    = expLength_q;
        expPkt_d       = expPkt_q;
        beatIdx_d      = beatIdx_q;
        sticky_d       = sticky_q;
        packetsRcvd_d  = packetsRcvd_q;
        errorCount_d   = errorCount_q;
        firstErrPkt_d  = firstErrPkt_q;
        firstErrCode_d = firstErrCode_q;

        // arm takes precedence over any beat accepted in the same cycle
        if (arm) begin
            state_d        = (expected_count == 64'd0) ? DONE : RUN;
            throttle_d     = '0;
            expCount_d     = expected_count;
            expLength_d    = (expected_length == 8'd0) ? 8'd4 : expected_length;
            expPkt_d       = 64'd0;
            beatIdx_d      = 8'd1;
            sticky_d       = 3'd0;
            packetsRcvd_d  = 64'd0;
            errorCount_d   = 32'd0;
            firstErrPkt_d  = 64'd0;
            firstErrCode_d = 3'd0;
        end else if (beatFire) begin
            if (AXIS_RX_TLAST) begin
                expPkt_d  = expPkt_q + 64'd1;
                beatIdx_d = 8'd1;
                sticky_d  = 3'd0;
                if (state_q == RUN) begin
                    packetsRcvd_d = packetsRcvd_q + 64'd1;
                    if (packetsRcvd_q + 64'd1 == expCount_q) begin
                        state_d = DONE;
                    end
                end
                if (pktCode != 3'd0) begin
                    if (errorCount_q != 32'hFFFF_FFFF) begin
                        errorCount_d = errorCount_q + 32'd1;
                    end
                    if (firstErrCode_q == 3'd0) begin
                        firstErrPkt_d  = expPkt_q;
                        firstErrCode_d = pktCode;
                    end
                end
            end else begin
                sticky_d  = pktCode;
                beatIdx_d = (beatIdx_q < expLength_q) ? beatIdx_q + 8'd1 : expLength_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            throttle_q     <= '0;
            expCount_q     <= 64'd0;
            expLength_q    <= 8'd4;
            expPkt_q       <= 64'd0;
            beatIdx_q      <= 8'd1;
            sticky_q       <= 3'd0;
            packetsRcvd_q  <= 64'd0;
            errorCount_q   <= 32'd0;
            firstErrPkt_q  <= 64'd0;
            firstErrCode_q <= 3'd0;
        end else begin
            state_q        <= state_d;
            throttle_q     <= throttle_d;
            expCount_q     <= expCount_d;
            expLength_q    <= expLength_d;
            expPkt_q       <= expPkt_d;
            beatIdx_q      <= beatIdx_d;
            sticky_q       <= sticky_d;
            packetsRcvd_q  <= packetsRcvd_d;
            errorCount_q   <= errorCount_d;
            firstErrPkt_q  <= firstErrPkt_d;
            firstErrCode_q <= firstErrCode_d;
        end
    end

endmodule

// File: tb/tb_packet_checker.sv
// Directed bench for packet_checker: one unthrottled instance and one with THROTTLE_PERIOD=2
// share the stream inputs; each is armed separately.
module tb_packet_checker;

    logic         clk = 1'b0;
    logic         reset;
    logic         armA, armT;
    logic [63:0]  expCount;
    logic [7:0]   expLength;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tvalid, tlast;

    logic        readyA, busyA, doneA, passA;
    logic [63:0] rcvdA, fepA;
    logic [31:0] errA;
    logic [2:0]  fecA;
    logic        readyT, busyT, doneT, passT;
    logic [63:0] rcvdT, fepT;
    logic [31:0] errT;
    logic [2:0]  fecT;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    packet_checker #(.THROTTLE_PERIOD(0)) dutA (
        .clk(clk), .reset(reset), .arm(armA),
        .expected_count(expCount), .expected_length(expLength),
        .AXIS_RX_TDATA(tdata), .AXIS_RX_TKEEP(tkeep),
        .AXIS_RX_TVALID(tvalid), .AXIS_RX_TLAST(tlast), .AXIS_RX_TREADY(readyA),
        .busy(busyA), .done(doneA), .pass(passA), .packets_rcvd(rcvdA),
        .error_count(errA), .first_err_pkt(fepA), .first_err_code(fecA)
    );

    packet_checker #(.THROTTLE_PERIOD(2)) dutT (
        .clk(clk), .reset(reset), .arm(armT),
        .expected_count(expCount), .expected_length(expLength),
        .AXIS_RX_TDATA(tdata), .AXIS_RX_TKEEP(tkeep),
        .AXIS_RX_TVALID(tvalid), .AXIS_RX_TLAST(tlast), .AXIS_RX_TREADY(readyT),
        .busy(busyT), .done(doneT), .pass(passT), .packets_rcvd(rcvdT),
        .error_count(errT), .first_err_pkt(fepT), .first_err_code(fecT)
    );

    // Present one beat and hold it until the selected instance accepts it.
    task automatic sendBeat(input logic sel, input logic [63:0] num, input int badLane,
                            input logic [63:0] keep, input logic last);
        logic accepted;
        tdata = {8{num}};
        if (badLane >= 0) begin
            tdata[badLane*64 +: 64] = num ^ 64'hDEAD_0000_0000_0001;
        end
        tkeep  = keep;
        tlast  = last;
        tvalid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = sel ? readyT : readyA;
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL beat_accept_timeout: pkt %0d not accepted within 50 cycles", num);
        end
    endtask

    task automatic sendPacket(input logic sel, input logic [63:0] num, input int nBeats,
                              input int badBeat, input int badLane, input int keepBeat);
        for (int b = 1; b <= nBeats; b++) begin
            sendBeat(sel, num, (b == badBeat) ? badLane : -1,
                     (b == keepBeat) ? 64'hFFFF_FFFF_FFFF_FFFE : {64{1'b1}}, b == nBeats);
        end
    endtask

    task automatic doArm(input logic sel, input logic [63:0] cnt, input logic [7:0] len);
        expCount  = cnt;
        expLength = len;
        if (sel) armT = 1'b1; else armA = 1'b1;
        @(posedge clk);
        #1;
        armA = 1'b0;
        armT = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (readyA !== 1'b0) begin bad++; $display("[TB] FAIL reset_tready: got %b want 0", readyA); end
        total++; if ({busyA, doneA, passA} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags: got %b want 000", {busyA, doneA, passA}); end
        total++; if (rcvdA !== 64'd0 || errA !== 32'd0) begin bad++; $display("[TB] FAIL reset_counters: got rcvd=%0d err=%0d want 0/0", rcvdA, errA); end
        total++; if (fepA !== 64'd0 || fecA !== 3'd0) begin bad++; $display("[TB] FAIL reset_first_err: got pkt=%0d code=%0d want 0/0", fepA, fecA); end
        // Partial packet cut by reset must never be counted.
        doArm(1'b0, 64'd1, 8'd4);
        sendBeat(1'b0, 64'd0, -1, {64{1'b1}}, 1'b0);
        sendBeat(1'b0, 64'd0, -1, {64{1'b1}}, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (busyA !== 1'b0 || rcvdA !== 64'd0 || readyA !== 1'b0) begin bad++; $display("[TB] FAIL reset_midpacket: got busy=%b rcvd=%0d tready=%b want 0/0/0", busyA, rcvdA, readyA); end
    endtask

    task automatic test_clean;
        doArm(1'b0, 64'd3, 8'd4);
        total++; if (busyA !== 1'b1 || doneA !== 1'b0 || readyA !== 1'b1) begin bad++; $display("[TB] FAIL clean_armed: got busy=%b done=%b tready=%b want 1/0/1", busyA, doneA, readyA); end
        sendPacket(1'b0, 64'd0, 4, 0, 0, 0);
        sendPacket(1'b0, 64'd1, 4, 0, 0, 0);
        total++; if (rcvdA !== 64'd2 || doneA !== 1'b0) begin bad++; $display("[TB] FAIL clean_mid: got rcvd=%0d done=%b want 2/0", rcvdA, doneA); end
        sendPacket(1'b0, 64'd2, 4, 0, 0, 0);
        total++; if ({busyA, doneA, passA} !== 3'b011) begin bad++; $display("[TB] FAIL clean_done: got busy/done/pass=%b want 011", {busyA, doneA, passA}); end
        total++; if (rcvdA !== 64'd3 || errA !== 32'd0 || fecA !== 3'd0) begin bad++; $display("[TB] FAIL clean_stats: got rcvd=%0d err=%0d code=%0d want 3/0/0", rcvdA, errA, fecA); end
    endtask

    task automatic test_data_err;
        doArm(1'b0, 64'd3, 8'd4);
        sendPacket(1'b0, 64'd0, 4, 0, 0, 0);
        sendPacket(1'b0, 64'd1, 4, 2, 5, 0);
        sendPacket(1'b0, 64'd2, 4, 0, 0, 0);
        total++; if (errA !== 32'd1 || fepA !== 64'd1 || fecA !== 3'd1) begin bad++; $display("[TB] FAIL data_err: got err=%0d pkt=%0d code=%0d want 1/1/1", errA, fepA, fecA); end
        total++; if (doneA !== 1'b1 || passA !== 1'b0 || rcvdA !== 64'd3) begin bad++; $display("[TB] FAIL data_err_done: got done=%b pass=%b rcvd=%0d want 1/0/3", doneA, passA, rcvdA); end
    endtask

    task automatic test_keep;
        doArm(1'b0, 64'd1, 8'd4);
        sendPacket(1'b0, 64'd0, 4, 0, 0, 3);
        total++; if (errA !== 32'd1 || fecA !== 3'd2 || fepA !== 64'd0) begin bad++; $display("[TB] FAIL keep_err: got err=%0d code=%0d pkt=%0d want 1/2/0", errA, fecA, fepA); end
        // Data and keep errors on the same beat: the lower code is reported.
        doArm(1'b0, 64'd1, 8'd4);
        sendPacket(1'b0, 64'd0, 4, 1, 0, 1);
        total++; if (errA !== 32'd1 || fecA !== 3'd1) begin bad++; $display("[TB] FAIL keep_data_priority: got err=%0d code=%0d want 1/1", errA, fecA); end
    endtask

    task automatic test_short_long;
        doArm(1'b0, 64'd3, 8'd4);
        sendPacket(1'b0, 64'd0, 3, 0, 0, 0);
        total++; if (errA !== 32'd1 || fecA !== 3'd3 || fepA !== 64'd0 || rcvdA !== 64'd1) begin bad++; $display("[TB] FAIL short_pkt: got err=%0d code=%0d pkt=%0d rcvd=%0d want 1/3/0/1", errA, fecA, fepA, rcvdA); end
        sendPacket(1'b0, 64'd1, 6, 0, 0, 0);
        total++; if (errA !== 32'd2 || fecA !== 3'd3 || rcvdA !== 64'd2) begin bad++; $display("[TB] FAIL long_pkt: got err=%0d code=%0d rcvd=%0d want 2/3/2", errA, fecA, rcvdA); end
        sendPacket(1'b0, 64'd2, 4, 0, 0, 0);
        total++; if (errA !== 32'd2 || rcvdA !== 64'd3 || doneA !== 1'b1 || passA !== 1'b0) begin bad++; $display("[TB] FAIL realign: got err=%0d rcvd=%0d done=%b pass=%b want 2/3/1/0", errA, rcvdA, doneA, passA); end
    endtask

    task automatic test_extra;
        doArm(1'b0, 64'd2, 8'd4);
        sendPacket(1'b0, 64'd0, 4, 0, 0, 0);
        sendPacket(1'b0, 64'd1, 4, 0, 0, 0);
        total++; if (doneA !== 1'b1 || passA !== 1'b1) begin bad++; $display("[TB] FAIL extra_pre: got done=%b pass=%b want 1/1", doneA, passA); end
        sendPacket(1'b0, 64'd2, 4, 0, 0, 0);
        total++; if (doneA !== 1'b1 || passA !== 1'b0 || errA !== 32'd1) begin bad++; $display("[TB] FAIL extra_flags: got done=%b pass=%b err=%0d want 1/0/1", doneA, passA, errA); end
        total++; if (fecA !== 3'd5 || fepA !== 64'd2 || rcvdA !== 64'd2) begin bad++; $display("[TB] FAIL extra_stats: got code=%0d pkt=%0d rcvd=%0d want 5/2/2", fecA, fepA, rcvdA); end
    endtask

    task automatic test_rearm;
        doArm(1'b0, 64'd5, 8'd4);
        sendPacket(1'b0, 64'd0, 4, 0, 0, 0);
        sendBeat(1'b0, 64'd1, -1, {64{1'b1}}, 1'b0);
        sendBeat(1'b0, 64'd1, -1, {64{1'b1}}, 1'b0);
        // arm coincides with a presented (and accepted) beat; the beat must be discarded
        tdata  = {8{64'd1}};
        tkeep  = {64{1'b1}};
        tlast  = 1'b0;
        tvalid = 1'b1;
        doArm(1'b0, 64'd2, 8'd4);
        tvalid = 1'b0;
        total++; if (rcvdA !== 64'd0 || errA !== 32'd0 || fecA !== 3'd0 || busyA !== 1'b1) begin bad++; $display("[TB] FAIL rearm_clear: got rcvd=%0d err=%0d code=%0d busy=%b want 0/0/0/1", rcvdA, errA, fecA, busyA); end
        sendPacket(1'b0, 64'd0, 4, 0, 0, 0);
        sendPacket(1'b0, 64'd1, 4, 0, 0, 0);
        total++; if (doneA !== 1'b1 || passA !== 1'b1 || rcvdA !== 64'd2) begin bad++; $display("[TB] FAIL rearm_run2: got done=%b pass=%b rcvd=%0d want 1/1/2", doneA, passA, rcvdA); end
        doArm(1'b0, 64'd0, 8'd4);
        total++; if (doneA !== 1'b1 || busyA !== 1'b0 || passA !== 1'b1) begin bad++; $display("[TB] FAIL zero_count: got done=%b busy=%b pass=%b want 1/0/1", doneA, busyA, passA); end
    endtask

    task automatic test_throttle;
        logic [5:0] seen;
        logic [5:0] want;
        want = 6'b110110;
        doArm(1'b1, 64'd2, 8'd0);
        for (int i = 0; i < 6; i++) begin
            seen[5-i] = readyT;
            @(posedge clk);
            #1;
        end
        total++; if (seen !== want) begin bad++; $display("[TB] FAIL throttle_pattern: got %b want %b", seen, want); end
        sendPacket(1'b1, 64'd0, 4, 0, 0, 0);
        sendPacket(1'b1, 64'd1, 4, 0, 0, 0);
        total++; if (doneT !== 1'b1 || passT !== 1'b1 || rcvdT !== 64'd2 || errT !== 32'd0) begin bad++; $display("[TB] FAIL throttle_run: got done=%b pass=%b rcvd=%0d err=%0d want 1/1/2/0", doneT, passT, rcvdT, errT); end
    endtask

    initial begin
        reset     = 1'b1;
        armA      = 1'b0;
        armT      = 1'b0;
        expCount  = 64'd0;
        expLength = 8'd0;
        tdata     = '0;
        tkeep     = '0;
        tvalid    = 1'b0;
        tlast     = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_clean;
        test_data_err;
        test_keep;
        test_short_long;
        test_extra;
        test_rearm;
        test_throttle;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
